// File: rtl/clint_timer.sv
// CLINT-style machine timer and software-interrupt block for HARTS harts.
// Zero-wait-state bus slave holding mtime (with prescaler), per-hart mtimecmp and msip.
module clint_timer #(
    parameter int unsigned HARTS    = 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    output logic [HARTS-1:0] timer_irq_out,
    output logic [HARTS-1:0] soft_irq_out,
    output logic [63:0]      mtime_out
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

    logic [63:0]      mtime_q, mtime_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [HARTS-1:0] msip_q, msip_d;
    logic [63:0]      mtimecmp_q [HARTS];
    logic [63:0]      mtimecmp_d [HARTS];
    logic [HARTS-1:0] timer_irq_q, timer_irq_d;

    logic [15:2] offset;
    logic        hit_msip, hit_cmp, hit_mtime, hi_word, wr_en, tick;
    logic [4:0]  msip_idx, cmp_idx;
    logic        unused_bits;

    // Address decode on word offsets; byte lane bits are don't-care.
    assign offset      = address_in[15:2];
    assign hit_msip    = (offset[15:7] == 9'h000);
    assign hit_cmp     = (offset[15:8] == 8'h40);
    assign hit_mtime   = (offset[15:3] == 13'h17FF);
    assign hi_word     = offset[2];
    assign msip_idx    = offset[6:2];
    assign cmp_idx     = offset[7:3];
    assign wr_en       = sel_in & (|write_mask_in);
    assign tick        = (psc_q == PSC_LAST);
    assign unused_bits = ^{read_in, address_in[31:16], address_in[1:0]};

    // Combinational read mux of current register values.
    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            if (hit_mtime) begin
                read_value_out = hi_word ? mtime_q[63:32] : mtime_q[31:0];
            end
            for (int h = 0; h < int'(HARTS); h++) begin
                if (hit_msip && (msip_idx == 5'(h))) begin
                    read_value_out = {31'h0, msip_q[h]};
                end
                if (hit_cmp && (cmp_idx == 5'(h))) begin
                    read_value_out = hi_word ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
                end
            end
        end
    end

    // Next state: bus writes take priority over the mtime increment.
    always_comb begin
        mtime_d     = mtime_q;
        psc_d       = tick ? '0 : psc_q + PSC_W'(1);
        msip_d      = msip_q;
        timer_irq_d = '0;
        for (int h = 0; h < int'(HARTS); h++) begin
            mtimecmp_d[h]  = mtimecmp_q[h];
            timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
        end

        if (wr_en && hit_mtime) begin
            psc_d = '0;
            if (hi_word) mtime_d[63:32] = merge_bytes(mtime_q[63:32], write_value_in, write_mask_in);
            else         mtime_d[31:0]  = merge_bytes(mtime_q[31:0], write_value_in, write_mask_in);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_en) begin
            for (int h = 0; h < int'(HARTS); h++) begin
                if (hit_msip && (msip_idx == 5'(h)) && write_mask_in[0]) begin
                    msip_d[h] = write_value_in[0];
                end
                if (hit_cmp && (cmp_idx == 5'(h))) begin
                    if (hi_word) begin
                        mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], write_value_in,
                                                           write_mask_in);
                    end else begin
                        mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0], write_value_in,
                                                          write_mask_in);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mtime_q     <= '0;
            psc_q       <= '0;
            msip_q      <= '0;
            timer_irq_q <= '0;
            for (int h = 0; h < int'(HARTS); h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            mtime_q     <= mtime_d;
            psc_q       <= psc_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
            for (int h = 0; h < int'(HARTS); h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign timer_irq_out = timer_irq_q;
    assign soft_irq_out  = msip_q;
    assign mtime_out     = mtime_q;
    assign ready_out     = sel_in;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (2 harts / prescale 1, 1 hart / prescale 4)
// checked against an arithmetic reference model (mtime = base + elapsed_clks / PRESCALE).
module tb_clint_timer;

    localparam int HA = 2, PA = 1, HB = 1, PB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic        sel   [2];
    logic        rd    [2];
    logic [3:0]  wm    [2];
    logic [31:0] wv    [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic [63:0] mt    [2];
    logic [1:0]  irq_a, sip_a;
    logic [0:0]  irq_b, sip_b;

    always #5 clk = ~clk;

    clint_timer #(.HARTS(HA), .PRESCALE(PA)) u_a (
        .clk(clk), .reset_(rst_n), .address_in(addr[0]), .sel_in(sel[0]), .read_in(rd[0]),
        .read_value_out(rdata[0]), .write_mask_in(wm[0]), .write_value_in(wv[0]),
        .ready_out(rdy[0]), .timer_irq_out(irq_a), .soft_irq_out(sip_a), .mtime_out(mt[0]));

    clint_timer #(.HARTS(HB), .PRESCALE(PB)) u_b (
        .clk(clk), .reset_(rst_n), .address_in(addr[1]), .sel_in(sel[1]), .read_in(rd[1]),
        .read_value_out(rdata[1]), .write_mask_in(wm[1]), .write_value_in(wv[1]),
        .ready_out(rdy[1]), .timer_irq_out(irq_b), .soft_irq_out(sip_b), .mtime_out(mt[1]));

    // Reference model state
    int          cyc = 0;
    int          np [2] = '{PA, PB};
    int          nh [2] = '{HA, HB};
    logic [63:0] m_base [2];
    int          m_n0   [2];
    logic [63:0] m_cmp  [2][2];
    logic        m_sip  [2][2];
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mtime_at(input int d, input int n);
        return m_base[d] + 64'((n - m_n0[d]) / np[d]);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int          off;
        int          h;
        logic [63:0] t;
        off = int'(a[15:0]) & 'hFFFC;
        t   = mtime_at(d, cyc);
        if (off < 4 * nh[d]) return {31'h0, m_sip[d][off / 4]};
        if (off >= 'h4000 && off < 'h4000 + 8 * nh[d]) begin
            h = (off - 'h4000) / 8;
            return (off % 8 == 4) ? m_cmp[d][h][63:32] : m_cmp[d][h][31:0];
        end
        if (off == 'hBFF8) return t[31:0];
        if (off == 'hBFFC) return t[63:32];
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    // Applied just after the write edge; pre is mtime as it stood before that edge.
    task automatic model_write(input int d, input logic [31:0] a, input logic [3:0] m,
                               input logic [31:0] v, input logic [63:0] pre);
        int off;
        int h;
        off = int'(a[15:0]) & 'hFFFC;
        if (m == 4'h0) return;
        if (off < 4 * nh[d]) begin
            if (m[0]) m_sip[d][off / 4] = v[0];
        end else if (off >= 'h4000 && off < 'h4000 + 8 * nh[d]) begin
            h = (off - 'h4000) / 8;
            if (off % 8 == 4) m_cmp[d][h][63:32] = merge(m_cmp[d][h][63:32], v, m);
            else              m_cmp[d][h][31:0]  = merge(m_cmp[d][h][31:0], v, m);
        end else if (off == 'hBFF8 || off == 'hBFFC) begin
            m_base[d] = pre;
            if (off == 'hBFFC) m_base[d][63:32] = merge(pre[63:32], v, m);
            else               m_base[d][31:0]  = merge(pre[31:0], v, m);
            m_n0[d] = cyc;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_base[d] = 64'h0;
            m_n0[d]   = cyc;
            for (int h = 0; h < 2; h++) begin
                m_cmp[d][h] = '1;
                m_sip[d][h] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input int d, input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] v);
        logic [63:0] pre;
        addr[d] = a; sel[d] = 1'b1; rd[d] = 1'b0; wm[d] = m; wv[d] = v;
        pre = mtime_at(d, cyc);
        @(posedge clk);
        #1;
        model_write(d, a, m, v, pre);
        sel[d] = 1'b0; wm[d] = 4'h0;
        @(negedge clk);
    endtask

    task automatic bus_read(input int d, input logic [31:0] a, input string tag);
        addr[d] = a; sel[d] = 1'b1; rd[d] = 1'b1; wm[d] = 4'h0;
        #1;
        chk(tag, 64'(rdata[d]), 64'(model_read(d, a)));
        chk({tag, "_rdy"}, 64'(rdy[d]), 64'd1);
        sel[d] = 1'b0; rd[d] = 1'b0;
        #1;
        chk({tag, "_idle0"}, 64'(rdata[d]), 64'h0);
        @(negedge clk);
    endtask

    function automatic logic [1:0] get_irq(input int d);
        return (d == 0) ? irq_a : {1'b0, irq_b};
    endfunction

    function automatic logic [1:0] get_sip(input int d);
        return (d == 0) ? sip_a : {1'b0, sip_b};
    endfunction

    // Requires at least one edge since the last write so cyc-1 is in the current model epoch.
    task automatic check_state(input int d, input string tag, input bit do_irq);
        logic [1:0]  e;
        logic [63:0] t;
        chk({tag, "_mtime"}, mt[d], mtime_at(d, cyc));
        chk({tag, "_sip"}, 64'(get_sip(d)), 64'({m_sip[d][1], m_sip[d][0]}));
        if (do_irq) begin
            e = 2'b00;
            t = mtime_at(d, cyc - 1);
            for (int h = 0; h < nh[d]; h++) e[h] = (t >= m_cmp[d][h]);
            chk({tag, "_irq"}, 64'(get_irq(d)), 64'(e));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          addrs [11] = '{'h0, 'h4, 'h8, 'h4000, 'h4004, 'h4008, 'h400C, 'h4010,
                                    'hBFF8, 'hBFFC, 'h1234};
        int          w;
        int          r;
        logic [31:0] a;
        logic [31:0] v;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; sel[d] = 1'b0; rd[d] = 1'b0; wm[d] = '0; wv[d] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Reset then idle
        idle(10);
        chk("t1_mtime_a", mt[0], 64'd10);
        chk("t1_mtime_b", mt[1], 64'd2);
        chk("t1_irq_a", 64'(irq_a), 64'h0);
        chk("t1_sip_a", 64'(sip_a), 64'h0);
        check_state(0, "t1a", 1);
        check_state(1, "t1b", 1);
        bus_read(0, 32'h4000, "t1_cmp0lo");
        bus_read(0, 32'h4004, "t1_cmp0hi");
        bus_read(0, 32'h400C, "t1_cmp1hi");

        // Prescaler restart on mtime write
        bus_write(1, 32'hBFF8, 4'hF, 32'd5);
        chk("t2_mtime_load", mt[1], 64'd5);
        idle(3);
        chk("t2_hold3", mt[1], 64'd5);
        idle(1);
        chk("t2_inc4", mt[1], 64'd6);
        check_state(1, "t2", 1);

        // Timer interrupt on hart 1
        bus_write(0, 32'hBFF8, 4'hF, 32'd0);
        bus_write(0, 32'h4008, 4'hF, 32'd20);
        bus_write(0, 32'h400C, 4'hF, 32'd0);
        w = 0;
        while (mt[0] != 64'd20 && w < 100) begin
            idle(1);
            w++;
        end
        chk("t3_reach20", mt[0], 64'd20);
        chk("t3_irq_pre", 64'(irq_a), 64'h0);
        idle(1);
        chk("t3_irq_on", 64'(irq_a), 64'h2);
        bus_write(0, 32'h400C, 4'hF, 32'hFFFF_FFFF);
        chk("t3_irq_old_cmp", 64'(irq_a), 64'h2);
        idle(1);
        chk("t3_irq_off", 64'(irq_a), 64'h0);
        check_state(0, "t3", 1);

        // Software interrupts
        bus_write(0, 32'h0004, 4'hF, 32'hFFFF_FFFF);
        chk("t4_sip_set", 64'(sip_a), 64'h2);
        bus_read(0, 32'h0004, "t4_rd_msip1");
        bus_write(0, 32'h0004, 4'hF, 32'h0);
        chk("t4_sip_clr", 64'(sip_a), 64'h0);
        bus_write(0, 32'h0008, 4'hF, 32'hFFFF_FFFF);
        chk("t4_sip_oob", 64'(sip_a), 64'h0);
        bus_read(0, 32'h0008, "t4_rd_oob");

        // mtime wrap
        bus_write(0, 32'hBFF8, 4'hF, 32'hFFFF_FFFE);
        bus_write(0, 32'hBFFC, 4'hF, 32'hFFFF_FFFF);
        chk("t5_load", mt[0], 64'hFFFF_FFFF_FFFF_FFFE);
        idle(2);
        chk("t5_wrap", mt[0], 64'h0);
        check_state(0, "t5", 1);
        bus_read(0, 32'hBFFC, "t5_rd_hi");

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 9);
                a = 32'(addrs[$urandom_range(0, 10)]) | 32'($urandom_range(0, 3));
                v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
                if (r < 4) begin
                    bus_write(d, a, 4'($urandom_range(0, 15)), v);
                    idle(1);
                    check_state(d, "rnd_wr", 1);
                end else if (r < 7) begin
                    bus_read(d, a, "rnd_rd");
                end else begin
                    idle($urandom_range(1, 6));
                    check_state(d, "rnd_idle", 1);
                end
            end
        end

        // Async reset in the middle of a write
        bus_write(0, 32'h0000, 4'h1, 32'h1);
        bus_write(0, 32'h4000, 4'hF, 32'h0);
        bus_write(0, 32'h4004, 4'hF, 32'h0);
        idle(2);
        chk("t6_irq_before", 64'(irq_a[0]), 64'h1);
        chk("t6_sip_before", 64'(sip_a[0]), 64'h1);
        addr[0] = 32'h4000; sel[0] = 1'b1; wm[0] = 4'hF; wv[0] = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mtime_a", mt[0], 64'h0);
        chk("t6_rst_mtime_b", mt[1], 64'h0);
        chk("t6_rst_irq", 64'(irq_a), 64'h0);
        chk("t6_rst_sip", 64'(sip_a), 64'h0);
        chk("t6_rst_cmp_rd", 64'(rdata[0]), 64'hFFFF_FFFF);
        @(negedge clk);
        sel[0] = 1'b0; wm[0] = 4'h0;
        rst_n = 1'b1;
        model_reset();
        bus_read(0, 32'h4000, "t6_write_dropped");
        bus_write(0, 32'h4000, 4'b0100, 32'hAABB_CCDD);
        addr[0] = 32'h4000; sel[0] = 1'b1; rd[0] = 1'b1;
        #1;
        chk("t6_bytemask", 64'(rdata[0]), 64'hFFBB_FFFF);
        sel[0] = 1'b0; rd[0] = 1'b0;
        bus_read(0, 32'h4000, "t6_bytemask_model");
        idle(1);
        check_state(0, "t6a", 1);
        check_state(1, "t6b", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
